// File: rtl/banked_mem_responder.sv
// Four-bank, word-interleaved memory responder: one request per cycle, fixed
// 2-cycle read latency, and a per-bank busy timer that stalls same-bank requests.
module banked_mem_responder #(
    parameter int ROW_BITS    = 13,
    parameter int BUSY_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        createdump,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);

    localparam int          WORDS     = 1 << ROW_BITS;
    localparam logic [2:0]  BUSY_LOAD = 3'(BUSY_CYCLES);

    logic                req;
    logic                accept;
    logic [1:0]          bank;
    logic [ROW_BITS-1:0] row;

    logic [15:0] mem [4][WORDS];
    logic [15:0] rd_word;
    logic [15:0] rd_data2;
    logic        rd_valid1;
    logic        rd_valid2;
    logic [2:0]  cnt [4];

    // createdump is a simulation hook only; upper address bits alias by design.
    logic unused_bits;
    assign unused_bits = ^{createdump, addr};

    assign bank   = addr[2:1];
    assign row    = addr[ROW_BITS+2:3];
    assign req    = rd | wr;
    assign err    = (rd & wr) | (req & addr[0]);
    assign stall  = req & ~err & busy[bank];
    assign accept = req & ~err & ~busy[bank];

    // Array is not reset; a write whose edge coincides with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && accept && wr) begin
            mem[bank][row] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        rd_word  <= mem[bank][row];
        rd_data2 <= rd_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid1 <= 1'b0;
            rd_valid2 <= 1'b0;
        end else begin
            rd_valid1 <= accept & rd;
            rd_valid2 <= rd_valid1;
        end
    end

    assign data_out = rd_valid2 ? rd_data2 : 16'h0000;

    for (genvar b = 0; b < 4; b++) begin : g_bank_timer
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt[b] <= 3'd0;
            end else if (accept && (bank == 2'(b))) begin
                cnt[b] <= BUSY_LOAD;
            end else if (cnt[b] != 3'd0) begin
                cnt[b] <= cnt[b] - 3'd1;
            end
        end

        assign busy[b] = (cnt[b] != 3'd0);
    end

endmodule

// File: tb/tb_banked_mem_responder.sv
// Directed bench for banked_mem_responder: a BUSY_CYCLES=3 instance plus a
// BUSY_CYCLES=1 instance sharing the same request stream.
module tb_banked_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        createdump;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;

    logic [15:0] data_out_a, data_out_b;
    logic        stall_a, stall_b;
    logic [3:0]  busy_a, busy_b;
    logic        err_a, err_b;

    int vectors     = 0;
    int miscompares = 0;

    banked_mem_responder #(.ROW_BITS(13), .BUSY_CYCLES(3)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .createdump (createdump),
        .addr       (addr),
        .data_in    (data_in),
        .wr         (wr),
        .rd         (rd),
        .data_out   (data_out_a),
        .stall      (stall_a),
        .busy       (busy_a),
        .err        (err_a)
    );

    banked_mem_responder #(.ROW_BITS(13), .BUSY_CYCLES(1)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .createdump (createdump),
        .addr       (addr),
        .data_in    (data_in),
        .wr         (wr),
        .rd         (rd),
        .data_out   (data_out_b),
        .stall      (stall_b),
        .busy       (busy_b),
        .err        (err_b)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle's inputs just after the rising edge, return at the falling edge.
    task automatic drive(input logic r, input logic r_rd, input logic r_wr,
                         input logic [15:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        rst     = r;
        rd      = r_rd;
        wr      = r_wr;
        addr    = a;
        data_in = d;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic expect_a(input string tag, input logic s, input logic e,
                            input logic [3:0] b, input logic [15:0] d);
        check_val({tag, ".stall"}, {15'd0, stall_a}, {15'd0, s});
        check_val({tag, ".err"},   {15'd0, err_a},   {15'd0, e});
        check_val({tag, ".busy"},  {12'd0, busy_a},  {12'd0, b});
        check_val({tag, ".dout"},  data_out_a,       d);
    endtask

    task automatic expect_b(input string tag, input logic s,
                            input logic [3:0] b, input logic [15:0] d);
        check_val({tag, ".stall"}, {15'd0, stall_b}, {15'd0, s});
        check_val({tag, ".busy"},  {12'd0, busy_b},  {12'd0, b});
        check_val({tag, ".dout"},  data_out_b,       d);
    endtask

    initial begin
        rst        = 1'b1;
        createdump = 1'b0;
        addr       = 16'h0000;
        data_in    = 16'h0000;
        wr         = 1'b0;
        rd         = 1'b0;
        @(negedge clk);
        expect_a("reset", 0, 0, 4'b0000, 16'h0000);
        expect_b("reset_b", 0, 4'b0000, 16'h0000);

        // Write then read, bank 0 row 2.
        drive(0, 0, 1, 16'h0010, 16'hBEEF); expect_a("A0", 0, 0, 4'b0000, 16'h0000);
        idle();                             expect_a("A1", 0, 0, 4'b0001, 16'h0000);
        idle();                             expect_a("A2", 0, 0, 4'b0001, 16'h0000);
        idle();                             expect_a("A3", 0, 0, 4'b0001, 16'h0000);
        drive(0, 1, 0, 16'h0010, 16'h0000); expect_a("A4", 0, 0, 4'b0000, 16'h0000);
        idle();                             expect_a("A5", 0, 0, 4'b0001, 16'h0000);
        idle();                             expect_a("A6", 0, 0, 4'b0001, 16'hBEEF);
        idle();                             expect_a("A7", 0, 0, 4'b0001, 16'h0000);
        idle();                             expect_a("A8", 0, 0, 4'b0000, 16'h0000);

        // Interleaved writes then reads across banks 0..3.
        drive(0, 0, 1, 16'h0000, 16'h0001); expect_a("B0", 0, 0, 4'b0000, 16'h0000);
        drive(0, 0, 1, 16'h0002, 16'h0002); expect_a("B1", 0, 0, 4'b0001, 16'h0000);
        drive(0, 0, 1, 16'h0004, 16'h0003); expect_a("B2", 0, 0, 4'b0011, 16'h0000);
        drive(0, 0, 1, 16'h0006, 16'h0004); expect_a("B3", 0, 0, 4'b0111, 16'h0000);
        drive(0, 1, 0, 16'h0000, 16'h0000); expect_a("B4", 0, 0, 4'b1110, 16'h0000);
        drive(0, 1, 0, 16'h0002, 16'h0000); expect_a("B5", 0, 0, 4'b1101, 16'h0000);
        drive(0, 1, 0, 16'h0004, 16'h0000); expect_a("B6", 0, 0, 4'b1011, 16'h0001);
        drive(0, 1, 0, 16'h0006, 16'h0000); expect_a("B7", 0, 0, 4'b0111, 16'h0002);
        idle();                             expect_a("B8", 0, 0, 4'b1110, 16'h0003);
        idle();                             expect_a("B9", 0, 0, 4'b1100, 16'h0004);
        idle();                             expect_a("B10", 0, 0, 4'b1000, 16'h0000);
        idle();                             expect_a("B11", 0, 0, 4'b0000, 16'h0000);

        // Same-bank read held under stall.
        drive(0, 0, 1, 16'h0008, 16'h1234); expect_a("C0", 0, 0, 4'b0000, 16'h0000);
        idle();                             expect_a("C1", 0, 0, 4'b0001, 16'h0000);
        idle();                             expect_a("C2", 0, 0, 4'b0001, 16'h0000);
        idle();                             expect_a("C3", 0, 0, 4'b0001, 16'h0000);
        drive(0, 1, 0, 16'h0008, 16'h0000); expect_a("C4", 0, 0, 4'b0000, 16'h0000);
        drive(0, 1, 0, 16'h0010, 16'h0000); expect_a("C5", 1, 0, 4'b0001, 16'h0000);
        drive(0, 1, 0, 16'h0010, 16'h0000); expect_a("C6", 1, 0, 4'b0001, 16'h1234);
        drive(0, 1, 0, 16'h0010, 16'h0000); expect_a("C7", 1, 0, 4'b0001, 16'h0000);
        drive(0, 1, 0, 16'h0010, 16'h0000); expect_a("C8", 0, 0, 4'b0000, 16'h0000);
        idle();                             expect_a("C9", 0, 0, 4'b0001, 16'h0000);
        idle();                             expect_a("C10", 0, 0, 4'b0001, 16'hBEEF);
        idle();                             expect_a("C11", 0, 0, 4'b0001, 16'h0000);
        idle();                             expect_a("C12", 0, 0, 4'b0000, 16'h0000);

        // Illegal requests: rd&wr on a busy bank, then an odd address.
        drive(0, 1, 0, 16'h0002, 16'h0000); expect_a("D0", 0, 0, 4'b0000, 16'h0000);
        drive(0, 1, 1, 16'h0002, 16'hDEAD); expect_a("D1", 0, 1, 4'b0010, 16'h0000);
        drive(0, 1, 0, 16'h0003, 16'h0000); expect_a("D2", 0, 1, 4'b0010, 16'h0002);
        idle();                             expect_a("D3", 0, 0, 4'b0010, 16'h0000);
        idle();                             expect_a("D4", 0, 0, 4'b0000, 16'h0000);
        drive(0, 1, 0, 16'h0002, 16'h0000); expect_a("D5", 0, 0, 4'b0000, 16'h0000);
        idle();                             expect_a("D6", 0, 0, 4'b0010, 16'h0000);
        idle();                             expect_a("D7", 0, 0, 4'b0010, 16'h0002);
        idle();                             expect_a("D8", 0, 0, 4'b0010, 16'h0000);
        idle();                             expect_a("D9", 0, 0, 4'b0000, 16'h0000);

        // Reset one cycle after a read is accepted.
        drive(0, 0, 1, 16'h0020, 16'hCAFE); expect_a("E0", 0, 0, 4'b0000, 16'h0000);
        idle();                             expect_a("E1", 0, 0, 4'b0001, 16'h0000);
        idle();                             expect_a("E2", 0, 0, 4'b0001, 16'h0000);
        idle();                             expect_a("E3", 0, 0, 4'b0001, 16'h0000);
        drive(0, 1, 0, 16'h0020, 16'h0000); expect_a("E4", 0, 0, 4'b0000, 16'h0000);
        drive(1, 0, 0, 16'h0000, 16'h0000); expect_a("E5", 0, 0, 4'b0000, 16'h0000);
        idle();                             expect_a("E6", 0, 0, 4'b0000, 16'h0000);
        idle();                             expect_a("E7", 0, 0, 4'b0000, 16'h0000);
        drive(0, 1, 0, 16'h0020, 16'h0000); expect_a("E8", 0, 0, 4'b0000, 16'h0000);
        idle();                             expect_a("E9", 0, 0, 4'b0001, 16'h0000);
        idle();                             expect_a("E10", 0, 0, 4'b0001, 16'hCAFE);
        idle();                             expect_a("E11", 0, 0, 4'b0001, 16'h0000);
        idle();                             expect_a("E12", 0, 0, 4'b0000, 16'h0000);

        // BUSY_CYCLES=1 instance: back-to-back same-bank reads.
        drive(0, 1, 0, 16'h0010, 16'h0000); expect_b("F0", 0, 4'b0000, 16'h0000);
        drive(0, 1, 0, 16'h0010, 16'h0000); expect_b("F1", 1, 4'b0001, 16'h0000);
        drive(0, 1, 0, 16'h0010, 16'h0000); expect_b("F2", 0, 4'b0000, 16'hBEEF);
        idle();                             expect_b("F3", 0, 4'b0001, 16'h0000);
        idle();                             expect_b("F4", 0, 4'b0000, 16'hBEEF);
        idle();                             expect_b("F5", 0, 4'b0000, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
